// File: rtl/niosii_system_data_unpack_adapter.sv
// Avalon-ST 32-bit to 8-bit unpacker, big-endian symbol order; first symbol one clk after beat capture.
// Output is a registered stage that freezes under out_ready=0; in_ready only rises when the held beat's last symbol loads.
module niosii_system_data_unpack_adapter (
    input  logic        clk,
    input  logic        reset_n,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [1:0]  in_empty,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket
);

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_sop_q, hold_sop_d;
    logic        hold_eop_q, hold_eop_d;
    logic [1:0]  hold_last_q, hold_last_d;
    logic [1:0]  idx_q, idx_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;

    logic        ld;
    logic        at_last;
    logic        hold_valid;
    logic        in_xfer;
    logic [7:0]  sym;

    always_comb begin
        ld         = out_ready | ~out_valid_q;
        hold_valid = (state_q == EMIT);
        at_last    = (idx_q == hold_last_q);
        in_ready   = ~hold_valid | (ld & at_last);
        in_xfer    = in_valid & in_ready;

        unique case (idx_q)
            2'd0:    sym = hold_data_q[31:24];
            2'd1:    sym = hold_data_q[23:16];
            2'd2:    sym = hold_data_q[15:8];
            default: sym = hold_data_q[7:0];
        endcase

        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_sop_d  = hold_sop_q;
        hold_eop_d  = hold_eop_q;
        hold_last_d = hold_last_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;

        // Framing bits are gated by hold_valid so they never appear on a bubble.
        if (ld) begin
            out_valid_d = hold_valid;
            out_data_d  = sym;
            out_sop_d   = hold_valid & hold_sop_q & (idx_q == 2'd0);
            out_eop_d   = hold_valid & hold_eop_q & at_last;
        end

        if (in_xfer) begin
            state_d     = EMIT;
            hold_data_d = in_data;
            hold_sop_d  = in_startofpacket;
            hold_eop_d  = in_endofpacket;
            hold_last_d = in_endofpacket ? (2'd3 - in_empty) : 2'd3;
            idx_d       = 2'd0;
        end else if (hold_valid && ld) begin
            if (at_last) begin
                state_d = EMPTY;
                idx_d   = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            hold_data_q <= '0;
            hold_sop_q  <= 1'b0;
            hold_eop_q  <= 1'b0;
            hold_last_q <= 2'd3;
            idx_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_sop_q  <= hold_sop_d;
            hold_eop_q  <= hold_eop_d;
            hold_last_q <= hold_last_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;

endmodule
